// File: rtl/cfu_cmd_sequencer_if.sv
// CFU command/response channel between an initiator (master) and the accelerator (slave).
interface cfu_cmd_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_payload_function_id;
  logic [31:0] cmd_payload_inputs_0;
  logic [31:0] cmd_payload_inputs_1;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_payload_outputs_0;

  modport master (
    output cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1,
    output rsp_ready,
    input  cmd_ready, rsp_valid, rsp_payload_outputs_0
  );

  modport slave (
    input  cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1,
    input  rsp_ready,
    output cmd_ready, rsp_valid, rsp_payload_outputs_0
  );
endinterface

// File: rtl/cfu_cmd_sequencer.sv
// CFU initiator: loads A/B buffers, starts the TPU, then streams the C buffer back out.
// One command outstanding at a time; each phase alternates ISSUE and WAIT.
module cfu_cmd_sequencer #(
  parameter int unsigned IDX_W   = 16,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [IDX_W-1:0]     cfg_a_words,
  input  logic [IDX_W-1:0]     cfg_b_words,
  input  logic [IDX_W-1:0]     cfg_c_rows,
  input  logic [15:0]          cfg_k,
  input  logic [15:0]          cfg_m,
  input  logic [15:0]          cfg_n,
  input  logic                 ld_valid,
  output logic                 ld_ready,
  input  logic [31:0]          ld_data,
  cfu_cmd_sequencer_if.master  cfu,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [31:0]          rd_data,
  output logic                 busy,
  output logic                 done,
  output logic [31:0]          run_result,
  output logic                 err_resp,
  output logic                 err_timeout
);
  localparam int unsigned TMO_W   = $clog2(TIMEOUT + 1);
  localparam logic [9:0]  FID_WR  = 10'd0;
  localparam logic [9:0]  FID_RUN = 10'd8;
  localparam logic [9:0]  FID_RD  = 10'd16;

  typedef enum logic [2:0] {S_IDLE, S_LOAD_A, S_LOAD_B, S_RUN, S_READ, S_DONE} state_e;

  state_e             state_q;
  logic               wait_q;
  logic               cmd_valid_q;
  logic [9:0]         fid_q;
  logic [31:0]        in0_q, in1_q;
  logic [IDX_W-1:0]   cnt_a_q, cnt_b_q, cnt_c_q, idx_q;
  logic [15:0]        k_q, m_q, n_q;
  logic [1:0]         off_q;
  logic [TMO_W-1:0]   tmo_q;
  logic               rd_valid_q;
  logic [31:0]        rd_data_q;
  logic               busy_q, done_q, err_resp_q, err_timeout_q;
  logic [31:0]        run_result_q;

  logic               in_load, issue_ok, rsp_ready_c, rsp_fire, ld_fire, cmd_fire;
  logic               last_load, last_row;
  logic [31:0]        rsp_data;

  assign in_load   = (state_q == S_LOAD_A) || (state_q == S_LOAD_B);
  assign issue_ok  = !wait_q && !cmd_valid_q;
  assign ld_ready  = in_load && issue_ok;
  assign ld_fire   = ld_valid && ld_ready;
  assign cmd_fire  = cmd_valid_q && cfu.cmd_ready;
  assign rsp_fire  = cfu.rsp_valid && rsp_ready_c;
  assign rsp_data  = cfu.rsp_payload_outputs_0;
  assign last_load = (idx_q == ((state_q == S_LOAD_A) ? cnt_a_q : cnt_b_q) - IDX_W'(1));
  assign last_row  = (idx_q == cnt_c_q - IDX_W'(1));

  // READ responses need room in the one-entry rd register (it may drain this cycle).
  always_comb begin
    rsp_ready_c = 1'b0;
    if (wait_q) begin
      case (state_q)
        S_LOAD_A, S_LOAD_B, S_RUN: rsp_ready_c = 1'b1;
        S_READ:                    rsp_ready_c = !rd_valid_q || rd_ready;
        default:                   rsp_ready_c = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      wait_q        <= 1'b0;
      cmd_valid_q   <= 1'b0;
      fid_q         <= '0;
      in0_q         <= '0;
      in1_q         <= '0;
      cnt_a_q       <= '0;
      cnt_b_q       <= '0;
      cnt_c_q       <= '0;
      idx_q         <= '0;
      k_q           <= '0;
      m_q           <= '0;
      n_q           <= '0;
      off_q         <= '0;
      tmo_q         <= '0;
      rd_valid_q    <= 1'b0;
      rd_data_q     <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_resp_q    <= 1'b0;
      err_timeout_q <= 1'b0;
      run_result_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (rd_valid_q && rd_ready) rd_valid_q <= 1'b0;

      // Timeout saturates at TIMEOUT; waiting continues regardless.
      if (cmd_fire) begin
        cmd_valid_q <= 1'b0;
        wait_q      <= 1'b1;
        tmo_q       <= '0;
      end else if (wait_q) begin
        if (tmo_q == TMO_W'(TIMEOUT)) err_timeout_q <= 1'b1;
        else                          tmo_q <= tmo_q + TMO_W'(1);
      end

      case (state_q)
        S_IDLE: begin
          if (start) begin
            cnt_a_q       <= cfg_a_words;
            cnt_b_q       <= cfg_b_words;
            cnt_c_q       <= cfg_c_rows;
            k_q           <= cfg_k;
            m_q           <= cfg_m;
            n_q           <= cfg_n;
            idx_q         <= '0;
            off_q         <= '0;
            busy_q        <= 1'b1;
            err_resp_q    <= 1'b0;
            err_timeout_q <= 1'b0;
            run_result_q  <= '0;
            if (cfg_a_words != '0)      state_q <= S_LOAD_A;
            else if (cfg_b_words != '0) state_q <= S_LOAD_B;
            else                        state_q <= S_RUN;
          end
        end
        S_LOAD_A, S_LOAD_B: begin
          if (ld_fire) begin
            cmd_valid_q <= 1'b1;
            fid_q       <= FID_WR;
            in0_q       <= ld_data;
            in1_q       <= {7'b0, (state_q == S_LOAD_B), 8'b0, 16'(idx_q)};
          end
          if (rsp_fire) begin
            wait_q <= 1'b0;
            if (rsp_data != '0) err_resp_q <= 1'b1;
            if (last_load) begin
              idx_q   <= '0;
              state_q <= (state_q == S_LOAD_A && cnt_b_q != '0) ? S_LOAD_B : S_RUN;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
        S_RUN: begin
          if (issue_ok) begin
            cmd_valid_q <= 1'b1;
            fid_q       <= FID_RUN;
            in0_q       <= {n_q, m_q};
            in1_q       <= {16'b0, k_q};
          end
          if (rsp_fire) begin
            wait_q       <= 1'b0;
            run_result_q <= rsp_data;
            if (cnt_c_q != '0) begin
              state_q <= S_READ;
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end
          end
        end
        S_READ: begin
          if (issue_ok) begin
            cmd_valid_q <= 1'b1;
            fid_q       <= FID_RD;
            in0_q       <= 32'(idx_q);
            in1_q       <= 32'(off_q);
          end
          if (rsp_fire) begin
            wait_q     <= 1'b0;
            rd_valid_q <= 1'b1;
            rd_data_q  <= rsp_data;
            off_q      <= off_q + 2'd1;
            if (off_q == 2'd3) begin
              if (last_row) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
              end else begin
                idx_q <= idx_q + IDX_W'(1);
              end
            end
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cfu.cmd_valid               = cmd_valid_q;
  assign cfu.cmd_payload_function_id = fid_q;
  assign cfu.cmd_payload_inputs_0    = in0_q;
  assign cfu.cmd_payload_inputs_1    = in1_q;
  assign cfu.rsp_ready               = rsp_ready_c;
  assign rd_valid                    = rd_valid_q;
  assign rd_data                     = rd_data_q;
  assign busy                        = busy_q;
  assign done                        = done_q;
  assign run_result                  = run_result_q;
  assign err_resp                    = err_resp_q;
  assign err_timeout                 = err_timeout_q;
endmodule
